// File: rtl/time_set_controller.sv
// time_set_controller: run/set sequencer for the time-of-day counter.
// Snapshots the running time on an edit request, steps the user through
// hours, minutes and seconds with next/up/down, then pulses a one-cycle
// load back to the counter. It also drives the blink strobe for the display.
// Optional feature macro: TIME_SET_AUTOREPEAT_EN (hold-to-repeat on up/down).
module time_set_controller #(
    parameter int unsigned BLINK_CYCLES   = 25000000,
    parameter int unsigned TIMEOUT_CYCLES = 500000000,
    parameter int unsigned HOLD_CYCLES    = 50000000,
    parameter int unsigned REPEAT_CYCLES  = 10000000
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       btn_edit,
    input  logic       btn_next,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [7:0] cur_hours,
    input  logic [7:0] cur_minutes,
    input  logic [7:0] cur_seconds,
    output logic [2:0] field_sel_o,
    output logic [7:0] edit_hours_o,
    output logic [7:0] edit_minutes_o,
    output logic [7:0] edit_seconds_o,
    output logic       load_o,
    output logic       pause_o,
    output logic       blink_o
);

    localparam int BW = $clog2(BLINK_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
    localparam logic [TW-1:0] IDLE_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_SET_H,
        ST_SET_M,
        ST_SET_S,
        ST_COMMIT
    } state_t;

    state_t          r_state;
    logic [2:0]      r_field_sel;
    logic [7:0]      r_edit_hr;
    logic [7:0]      r_edit_min;
    logic [7:0]      r_edit_sec;
    logic            r_load;
    logic            r_pause;
    logic            r_blink;
    logic [BW-1:0]   r_blink_cnt;
    logic [TW-1:0]   r_idle_cnt;

    // Button sample and previous sample, bit order {edit, next, up, down}
    logic [3:0]      r_btn_s;
    logic [3:0]      r_btn_d;
    logic [3:0]      w_press;
    logic            w_p_edit;
    logic            w_p_next;
    logic            w_p_up;
    logic            w_p_down;
    logic            w_in_set;
    logic            w_rep_step;
    logic            w_rep_down;
    logic            w_step_up;
    logic            w_step_dn;
    logic [7:0]      w_sel_val;
    logic [7:0]      w_sel_max;
    logic [7:0]      w_sel_inc;
    logic [7:0]      w_sel_dec;

    assign w_press  = r_btn_s & ~r_btn_d;
    assign w_p_edit = w_press[3];
    assign w_p_next = w_press[2];
    assign w_p_up   = w_press[1];
    assign w_p_down = w_press[0];
    assign w_in_set = (r_state == ST_SET_H) || (r_state == ST_SET_M) || (r_state == ST_SET_S);

    // Up/down requests after priority: a real press beats a repeat step
    assign w_step_up = w_p_up || (w_rep_step && !w_rep_down);
    assign w_step_dn = !w_p_up && (w_p_down || (w_rep_step && w_rep_down));

    // Sample the button levels and keep the previous sample for edge detection
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_btn_s <= '0;
            r_btn_d <= '0;
        end else begin
            r_btn_s <= {btn_edit, btn_next, btn_up, btn_down};
            r_btn_d <= r_btn_s;
        end
    end

    // Currently selected field value and its wrap limit, with +1/-1 results
    always_comb begin
        w_sel_val = r_edit_sec;
        w_sel_max = 8'd59;
        if (r_state == ST_SET_H) begin
            w_sel_val = r_edit_hr;
            w_sel_max = 8'd23;
        end else if (r_state == ST_SET_M) begin
            w_sel_val = r_edit_min;
        end
        w_sel_inc = (w_sel_val >= w_sel_max) ? 8'd0 : w_sel_val + 8'd1;
        w_sel_dec = ((w_sel_val == 8'd0) || (w_sel_val > w_sel_max)) ? w_sel_max : w_sel_val - 8'd1;
    end

`ifdef TIME_SET_AUTOREPEAT_EN
    localparam int RW = $clog2(((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES) + 1);

    logic          r_rep_active;
    logic          r_rep_down;
    logic          r_rep_phase;
    logic [RW-1:0] r_rep_cnt;
    logic          w_rep_held;
    logic [RW-1:0] w_rep_last;

    assign w_rep_held = r_rep_down ? r_btn_s[0] : r_btn_s[1];
    assign w_rep_last = r_rep_phase ? RW'(REPEAT_CYCLES - 1) : RW'(HOLD_CYCLES - 1);
    assign w_rep_step = r_rep_active && w_rep_held && w_in_set &&
                        (w_press == 4'b0000) && (r_rep_cnt == w_rep_last);
    assign w_rep_down = r_rep_down;

    // Hold/repeat timer: armed by an up/down press, first step after the hold
    // time, then one step per repeat period until release or any interruption
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_rep_active <= 1'b0;
            r_rep_down   <= 1'b0;
            r_rep_phase  <= 1'b0;
            r_rep_cnt    <= '0;
        end else if (!w_in_set || w_p_edit || w_p_next) begin
            r_rep_active <= 1'b0;
        end else if (w_p_up || w_p_down) begin
            r_rep_active <= 1'b1;
            r_rep_down   <= !w_p_up;
            r_rep_phase  <= 1'b0;
            r_rep_cnt    <= '0;
        end else if (r_rep_active) begin
            if (!w_rep_held) begin
                r_rep_active <= 1'b0;
            end else if (w_rep_step) begin
                r_rep_phase <= 1'b1;
                r_rep_cnt   <= '0;
            end else begin
                r_rep_cnt <= r_rep_cnt + 1'b1;
            end
        end
    end
`else
    assign w_rep_step = 1'b0;
    // Direction is irrelevant without repeat steps; tying it to the repeat
    // parameters keeps one parameter list meaningful in both builds.
    assign w_rep_down = (HOLD_CYCLES == 0) || (REPEAT_CYCLES == 0);
`endif

    // Main sequencer: state, edit registers, blink and idle timeout, all registered
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_field_sel <= 3'b000;
            r_edit_hr   <= 8'd0;
            r_edit_min  <= 8'd0;
            r_edit_sec  <= 8'd0;
            r_load      <= 1'b0;
            r_pause     <= 1'b0;
            r_blink     <= 1'b0;
            r_blink_cnt <= '0;
            r_idle_cnt  <= '0;
        end else begin
            r_load <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (w_p_edit) begin
                        r_edit_hr   <= cur_hours;
                        r_edit_min  <= cur_minutes;
                        r_edit_sec  <= cur_seconds;
                        r_state     <= ST_SET_H;
                        r_field_sel <= 3'b100;
                        r_pause     <= 1'b1;
                        r_blink     <= 1'b1;
                        r_blink_cnt <= '0;
                        r_idle_cnt  <= '0;
                    end
                end
                ST_SET_H, ST_SET_M, ST_SET_S: begin
                    if (w_p_edit) begin
                        r_state     <= ST_RUN;
                        r_field_sel <= 3'b000;
                        r_pause     <= 1'b0;
                        r_blink     <= 1'b0;
                    end else if (w_p_next) begin
                        r_idle_cnt  <= '0;
                        r_blink_cnt <= '0;
                        if (r_state == ST_SET_S) begin
                            r_state     <= ST_COMMIT;
                            r_field_sel <= 3'b000;
                            r_load      <= 1'b1;
                            r_blink     <= 1'b0;
                        end else begin
                            r_state     <= (r_state == ST_SET_H) ? ST_SET_M : ST_SET_S;
                            r_field_sel <= r_field_sel >> 1;
                            r_blink     <= 1'b1;
                        end
                    end else begin
                        if (r_blink_cnt == BLINK_LAST) begin
                            r_blink     <= ~r_blink;
                            r_blink_cnt <= '0;
                        end else begin
                            r_blink_cnt <= r_blink_cnt + 1'b1;
                        end
                        if (w_step_up || w_step_dn) begin
                            r_idle_cnt <= '0;
                            if (r_state == ST_SET_H) begin
                                r_edit_hr <= w_step_up ? w_sel_inc : w_sel_dec;
                            end else if (r_state == ST_SET_M) begin
                                r_edit_min <= w_step_up ? w_sel_inc : w_sel_dec;
                            end else begin
                                r_edit_sec <= w_step_up ? w_sel_inc : w_sel_dec;
                            end
                        end else if (r_idle_cnt == IDLE_LAST) begin
                            // Abandon the edit; the counter keeps its own time
                            r_state     <= ST_RUN;
                            r_field_sel <= 3'b000;
                            r_pause     <= 1'b0;
                            r_blink     <= 1'b0;
                            r_idle_cnt  <= '0;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    r_state <= ST_RUN;
                    r_pause <= 1'b0;
                end
                default: begin
                    r_state     <= ST_RUN;
                    r_field_sel <= 3'b000;
                    r_pause     <= 1'b0;
                    r_blink     <= 1'b0;
                end
            endcase
        end
    end

    assign field_sel_o    = r_field_sel;
    assign edit_hours_o   = r_edit_hr;
    assign edit_minutes_o = r_edit_min;
    assign edit_seconds_o = r_edit_sec;
    assign load_o         = r_load;
    assign pause_o        = r_pause;
    assign blink_o        = r_blink;

endmodule

// File: tb/tb_time_set_controller.sv
// Bench for time_set_controller: directed scenarios plus a randomized walk
// compared against a cycle-level behavioural model of the set sequence.
module tb_time_set_controller;

    localparam int BLINK   = 4;
    localparam int TIMEOUT = 50;
    localparam int HOLD    = 8;
    localparam int REPEAT  = 3;

    logic       clk_in = 1'b0;
    logic       reset = 1'b1;
    logic       btn_edit = 1'b0, btn_next = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic [7:0] cur_hours = 8'd0, cur_minutes = 8'd0, cur_seconds = 8'd0;
    logic [2:0] field_sel_o;
    logic [7:0] edit_hours_o, edit_minutes_o, edit_seconds_o;
    logic       load_o, pause_o, blink_o;

    int total = 0;
    int bad = 0;
    int load_cnt = 0;

    time_set_controller #(
        .BLINK_CYCLES(BLINK), .TIMEOUT_CYCLES(TIMEOUT),
        .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REPEAT)
    ) dut (
        .clk_in(clk_in), .reset(reset),
        .btn_edit(btn_edit), .btn_next(btn_next), .btn_up(btn_up), .btn_down(btn_down),
        .cur_hours(cur_hours), .cur_minutes(cur_minutes), .cur_seconds(cur_seconds),
        .field_sel_o(field_sel_o), .edit_hours_o(edit_hours_o),
        .edit_minutes_o(edit_minutes_o), .edit_seconds_o(edit_seconds_o),
        .load_o(load_o), .pause_o(pause_o), .blink_o(blink_o)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) if (load_o === 1'b1) load_cnt++;

    // ---------------- behavioural model ----------------
    // mode: 0 run, 1 hours, 2 minutes, 3 seconds, 4 commit
    int m_mode, m_edge, m_entry, m_act, m_p;
    int m_f[3];
    bit m_load, m_rep, m_rep_down;
    bit s_e, s_n, s_u, s_d, d_e, d_n, d_u, d_d;

    task automatic model_reset();
        m_mode = 0; m_edge = 0; m_entry = 0; m_act = 0; m_p = 0;
        m_f[0] = 0; m_f[1] = 0; m_f[2] = 0;
        m_load = 0; m_rep = 0; m_rep_down = 0;
        {s_e, s_n, s_u, s_d, d_e, d_n, d_u, d_d} = '0;
    endtask

    task automatic m_bump(input int dir);
        int idx, lim;
        idx = m_mode - 1;
        lim = (idx == 0) ? 24 : 60;
        m_f[idx] = (m_f[idx] + dir + lim) % lim;
    endtask

    task automatic model_edge();
        bit pe, pn, pu, pd, held, stepped;
        int k;
        pe = s_e && !d_e; pn = s_n && !d_n; pu = s_u && !d_u; pd = s_d && !d_d;
        m_load = 0;
        if (m_mode == 0) begin
            m_rep = 0;
            if (pe) begin
                m_f[0] = int'(cur_hours); m_f[1] = int'(cur_minutes); m_f[2] = int'(cur_seconds);
                m_mode = 1; m_entry = m_edge; m_act = m_edge;
            end
        end else if (m_mode == 4) begin
            m_mode = 0; m_rep = 0;
        end else if (pe) begin
            m_mode = 0; m_rep = 0;
        end else if (pn) begin
            m_rep = 0; m_act = m_edge;
            if (m_mode == 3) begin m_mode = 4; m_load = 1; end
            else begin m_mode++; m_entry = m_edge; end
        end else if (pu || pd) begin
            m_bump(pu ? 1 : -1);
            m_act = m_edge; m_rep = 1; m_rep_down = !pu; m_p = m_edge;
        end else begin
            stepped = 0;
`ifdef TIME_SET_AUTOREPEAT_EN
            if (m_rep) begin
                held = m_rep_down ? s_d : s_u;
                k = m_edge - m_p;
                if (!held) m_rep = 0;
                else if (k == HOLD || (k > HOLD && (k - HOLD) % REPEAT == 0)) begin
                    m_bump(m_rep_down ? -1 : 1);
                    m_act = m_edge; stepped = 1;
                end
            end
`else
            held = 0; k = 0;
`endif
            if (!stepped && (m_edge - m_act) == TIMEOUT) begin
                m_mode = 0; m_rep = 0;
            end
        end
        {d_e, d_n, d_u, d_d} = {s_e, s_n, s_u, s_d};
        {s_e, s_n, s_u, s_d} = {btn_edit, btn_next, btn_up, btn_down};
        m_edge++;
    endtask

    function automatic logic [2:0] m_sel();
        return (m_mode == 1) ? 3'b100 : (m_mode == 2) ? 3'b010 : (m_mode == 3) ? 3'b001 : 3'b000;
    endfunction

    function automatic logic m_blink();
        if (m_mode < 1 || m_mode > 3) return 1'b0;
        return (((m_edge - 1 - m_entry) / BLINK) % 2) == 0;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk_in);
        model_edge();
        @(negedge clk_in);
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: btn_edit = v;
            1: btn_next = v;
            2: btn_up = v;
            default: btn_down = v;
        endcase
    endtask

    task automatic press(input int b);
        set_btn(b, 1'b1); cyc();
        set_btn(b, 1'b0); cyc();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk_in);
        reset = 1'b0;
        model_reset();
        cyc();
        total += 7;
        if (field_sel_o !== 3'b000) begin bad++; $display("FAIL reset_field got=%b exp=000", field_sel_o); end
        if (edit_hours_o !== 8'd0) begin bad++; $display("FAIL reset_hours got=%0d exp=0", edit_hours_o); end
        if (edit_minutes_o !== 8'd0) begin bad++; $display("FAIL reset_minutes got=%0d exp=0", edit_minutes_o); end
        if (edit_seconds_o !== 8'd0) begin bad++; $display("FAIL reset_seconds got=%0d exp=0", edit_seconds_o); end
        if (load_o !== 1'b0) begin bad++; $display("FAIL reset_load got=%b exp=0", load_o); end
        if (pause_o !== 1'b0) begin bad++; $display("FAIL reset_pause got=%b exp=0", pause_o); end
        if (blink_o !== 1'b0) begin bad++; $display("FAIL reset_blink got=%b exp=0", blink_o); end
        $display("reset: outputs checked");
    endtask

    task automatic test_snapshot_commit();
        int lc0;
        lc0 = load_cnt;
        cur_hours = 8'd12; cur_minutes = 8'd34; cur_seconds = 8'd56;
        press(0);
        total += 6;
        if (edit_hours_o !== 8'd12) begin bad++; $display("FAIL snap_hours got=%0d exp=12", edit_hours_o); end
        if (edit_minutes_o !== 8'd34) begin bad++; $display("FAIL snap_minutes got=%0d exp=34", edit_minutes_o); end
        if (edit_seconds_o !== 8'd56) begin bad++; $display("FAIL snap_seconds got=%0d exp=56", edit_seconds_o); end
        if (field_sel_o !== 3'b100) begin bad++; $display("FAIL snap_field got=%b exp=100", field_sel_o); end
        if (pause_o !== 1'b1) begin bad++; $display("FAIL snap_pause got=%b exp=1", pause_o); end
        if (blink_o !== 1'b1) begin bad++; $display("FAIL snap_blink_entry got=%b exp=1", blink_o); end
        press(1); press(1); press(1);
        total += 3;
        if (load_o !== 1'b1) begin bad++; $display("FAIL commit_load got=%b exp=1", load_o); end
        if (pause_o !== 1'b1) begin bad++; $display("FAIL commit_pause got=%b exp=1", pause_o); end
        if (field_sel_o !== 3'b000) begin bad++; $display("FAIL commit_field got=%b exp=000", field_sel_o); end
        cyc();
        total += 2;
        if (load_o !== 1'b0) begin bad++; $display("FAIL post_commit_load got=%b exp=0", load_o); end
        if (pause_o !== 1'b0) begin bad++; $display("FAIL post_commit_pause got=%b exp=0", pause_o); end
        repeat (3) cyc();
        total++;
        if (load_cnt - lc0 !== 1) begin bad++; $display("FAIL commit_load_count got=%0d exp=1", load_cnt - lc0); end
        $display("snapshot/commit: 12:34:56 loaded");
    endtask

    task automatic test_wrap();
        cur_hours = 8'd23; cur_minutes = 8'd59; cur_seconds = 8'd0;
        press(0); press(2); press(1); press(2); press(1); press(3); press(1);
        total += 4;
        if (load_o !== 1'b1) begin bad++; $display("FAIL wrap_load got=%b exp=1", load_o); end
        if (edit_hours_o !== 8'd0) begin bad++; $display("FAIL wrap_hours got=%0d exp=0", edit_hours_o); end
        if (edit_minutes_o !== 8'd0) begin bad++; $display("FAIL wrap_minutes got=%0d exp=0", edit_minutes_o); end
        if (edit_seconds_o !== 8'd59) begin bad++; $display("FAIL wrap_seconds got=%0d exp=59", edit_seconds_o); end
        cyc();
        $display("wrap: 23:59:00 -> 00:00:59");
    endtask

    task automatic test_cancel();
        int lc0;
        lc0 = load_cnt;
        cur_hours = 8'd5; cur_minutes = 8'd20; cur_seconds = 8'd30;
        press(0); press(2);
        total++;
        if (edit_hours_o !== 8'd6) begin bad++; $display("FAIL cancel_up got=%0d exp=6", edit_hours_o); end
        press(0);
        repeat (2) cyc();
        total += 3;
        if (field_sel_o !== 3'b000) begin bad++; $display("FAIL cancel_field got=%b exp=000", field_sel_o); end
        if (pause_o !== 1'b0) begin bad++; $display("FAIL cancel_pause got=%b exp=0", pause_o); end
        if (load_cnt !== lc0) begin bad++; $display("FAIL cancel_load got=%0d exp=%0d", load_cnt, lc0); end
        $display("cancel: back to run without load");
    endtask

    task automatic test_timeout();
        int lc0;
        lc0 = load_cnt;
        cur_hours = 8'($urandom_range(0, 23)); cur_minutes = 8'($urandom_range(0, 59));
        press(0); press(1);
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            total += 2;
            if (field_sel_o !== 3'b010) begin bad++; $display("FAIL timeout_wait_field cyc=%0d got=%b exp=010", i, field_sel_o); end
            if (blink_o !== m_blink()) begin bad++; $display("FAIL timeout_blink cyc=%0d got=%b exp=%b", i, blink_o, m_blink()); end
            cyc();
        end
        total++;
        if (field_sel_o !== 3'b010) begin bad++; $display("FAIL timeout_early got=%b exp=010", field_sel_o); end
        cyc();
        total += 4;
        if (field_sel_o !== 3'b000) begin bad++; $display("FAIL timeout_field got=%b exp=000", field_sel_o); end
        if (pause_o !== 1'b0) begin bad++; $display("FAIL timeout_pause got=%b exp=0", pause_o); end
        if (blink_o !== 1'b0) begin bad++; $display("FAIL timeout_blink_run got=%b exp=0", blink_o); end
        if (load_cnt !== lc0) begin bad++; $display("FAIL timeout_load got=%0d exp=%0d", load_cnt, lc0); end
        $display("timeout: edit abandoned after %0d idle cycles", TIMEOUT);
    endtask

    task automatic test_priority();
        int h;
        h = $urandom_range(0, 23);
        cur_hours = 8'(h);
        press(0);
        btn_next = 1'b1; btn_up = 1'b1; cyc();
        btn_next = 1'b0; btn_up = 1'b0; cyc();
        total += 2;
        if (field_sel_o !== 3'b010) begin bad++; $display("FAIL prio_field got=%b exp=010", field_sel_o); end
        if (edit_hours_o !== 8'(h)) begin bad++; $display("FAIL prio_hours got=%0d exp=%0d", edit_hours_o, h); end
        press(0); cyc();
        $display("priority: next beats up, hours=%0d", h);
    endtask

    task automatic test_hold();
        int m;
`ifdef TIME_SET_AUTOREPEAT_EN
        m = 10;
        cur_minutes = 8'(m);
        press(0); press(1);
        btn_up = 1'b1;
        cyc(); cyc();
        total++;
        if (edit_minutes_o !== 8'd11) begin bad++; $display("FAIL repeat_first got=%0d exp=11", edit_minutes_o); end
        repeat (19) cyc();
        btn_up = 1'b0;
        repeat (4) cyc();
        total += 2;
        if (edit_minutes_o !== 8'd16) begin bad++; $display("FAIL repeat_final got=%0d exp=16", edit_minutes_o); end
        if (edit_minutes_o !== 8'(m_f[1])) begin bad++; $display("FAIL repeat_model got=%0d exp=%0d", edit_minutes_o, m_f[1]); end
        $display("autorepeat: minutes 10 -> %0d", edit_minutes_o);
`else
        m = $urandom_range(0, 59);
        cur_minutes = 8'(m);
        press(0); press(1);
        btn_up = 1'b1;
        repeat (20) cyc();
        btn_up = 1'b0;
        repeat (2) cyc();
        total++;
        if (edit_minutes_o !== 8'((m + 1) % 60)) begin bad++; $display("FAIL hold_single got=%0d exp=%0d", edit_minutes_o, (m + 1) % 60); end
        $display("hold: minutes %0d -> %0d", m, edit_minutes_o);
`endif
        press(0); cyc();
    endtask

    task automatic test_reset_mid_edit();
        int lc0;
        lc0 = load_cnt;
        cur_hours = 8'd7; cur_minutes = 8'd8; cur_seconds = 8'd9;
        press(0); press(1); press(1);
        total++;
        if (field_sel_o !== 3'b001) begin bad++; $display("FAIL midrst_pre got=%b exp=001", field_sel_o); end
        #2 reset = 1'b1;
        #1;
        total += 7;
        if (field_sel_o !== 3'b000) begin bad++; $display("FAIL midrst_field got=%b exp=000", field_sel_o); end
        if (pause_o !== 1'b0) begin bad++; $display("FAIL midrst_pause got=%b exp=0", pause_o); end
        if (blink_o !== 1'b0) begin bad++; $display("FAIL midrst_blink got=%b exp=0", blink_o); end
        if (load_o !== 1'b0) begin bad++; $display("FAIL midrst_load got=%b exp=0", load_o); end
        if (edit_hours_o !== 8'd0) begin bad++; $display("FAIL midrst_hours got=%0d exp=0", edit_hours_o); end
        if (edit_minutes_o !== 8'd0) begin bad++; $display("FAIL midrst_minutes got=%0d exp=0", edit_minutes_o); end
        if (edit_seconds_o !== 8'd0) begin bad++; $display("FAIL midrst_seconds got=%0d exp=0", edit_seconds_o); end
        @(negedge clk_in); @(negedge clk_in);
        reset = 1'b0;
        model_reset();
        repeat (2) cyc();
        total++;
        if (load_cnt !== lc0) begin bad++; $display("FAIL midrst_no_load got=%0d exp=%0d", load_cnt, lc0); end
        $display("reset mid-edit: outputs cleared asynchronously");
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 600; i++) begin
            if ((i % 150) >= 80) begin
                btn_edit = 1'b0; btn_next = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
            end else begin
                btn_edit = ($urandom_range(0, 15) == 0);
                btn_next = ($urandom_range(0, 4) == 0);
                btn_up   = ($urandom_range(0, 2) == 0);
                btn_down = ($urandom_range(0, 2) == 0);
            end
            cur_hours   = 8'($urandom_range(0, 23));
            cur_minutes = 8'($urandom_range(0, 59));
            cur_seconds = 8'($urandom_range(0, 59));
            cyc();
            total += 7;
            if (field_sel_o !== m_sel()) begin bad++; errs++; $display("FAIL rnd_field cyc=%0d got=%b exp=%b", i, field_sel_o, m_sel()); end
            if (edit_hours_o !== 8'(m_f[0])) begin bad++; errs++; $display("FAIL rnd_hours cyc=%0d got=%0d exp=%0d", i, edit_hours_o, m_f[0]); end
            if (edit_minutes_o !== 8'(m_f[1])) begin bad++; errs++; $display("FAIL rnd_minutes cyc=%0d got=%0d exp=%0d", i, edit_minutes_o, m_f[1]); end
            if (edit_seconds_o !== 8'(m_f[2])) begin bad++; errs++; $display("FAIL rnd_seconds cyc=%0d got=%0d exp=%0d", i, edit_seconds_o, m_f[2]); end
            if (load_o !== m_load) begin bad++; errs++; $display("FAIL rnd_load cyc=%0d got=%b exp=%b", i, load_o, m_load); end
            if (pause_o !== (m_mode != 0)) begin bad++; errs++; $display("FAIL rnd_pause cyc=%0d got=%b exp=%b", i, pause_o, (m_mode != 0)); end
            if (blink_o !== m_blink()) begin bad++; errs++; $display("FAIL rnd_blink cyc=%0d got=%b exp=%b", i, blink_o, m_blink()); end
        end
        btn_edit = 1'b0; btn_next = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        repeat (TIMEOUT + 5) cyc();
        $display("random walk: 600 cycles, %0d discrepancies", errs);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_snapshot_commit();
        test_wrap();
        test_cancel();
        test_timeout();
        test_priority();
        test_hold();
        test_reset_mid_edit();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
